ast_video_frame_parser: RTL and testbench
=========================================

Name: ast_video_frame_parser

Overview:
- Avalon-ST video sink placed directly downstream of the BT.656-to-AST converter.
- Consumes the control packet (type 0xF) and video packet (type 0x0) stream, and latches frame width, height and interlace nibble.
- Strips packet headers and emits Y pixels tagged with x/y coordinates and start-of-frame/end-of-line/end-of-frame marks for the frame-processing stages that follow.
- Detects and flags malformed packets.

Parameters:
- DATA_WIDTH, 8, width of the pixel/beat data.
- MAX_WIDTH, 640, largest accepted frame width; also the default width used before any valid control packet.
- MAX_HEIGHT, 480, largest accepted frame height; also the default height used before any valid control packet.

Ports:
- clock, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- din_data, in, DATA_WIDTH, Avalon-ST sink data.
- din_valid, in, 1, sink valid.
- din_startofpacket, in, 1, sink SOP.
- din_endofpacket, in, 1, sink EOP.
- din_ready, out, 1, sink ready (ready latency 0).
- pix_data, out, DATA_WIDTH, pixel value.
- pix_valid, out, 1, pixel valid.
- pix_ready, in, 1, downstream accept.
- pix_x, out, 12, column of the current pixel.
- pix_y, out, 12, row of the current pixel.
- pix_sof, out, 1, first pixel of the frame.
- pix_eol, out, 1, last pixel of the line.
- pix_eof, out, 1, last pixel of the frame.
- frame_width, out, 12, active width.
- frame_height, out, 12, active height.
- frame_interlace, out, 4, last accepted interlace nibble.
- err_ctrl, out, 1, one-cycle pulse: malformed control packet.
- err_short, out, 1, one-cycle pulse: video packet ended early.
- err_long, out, 1, one-cycle pulse: video packet too long.
- frame_count, out, 16, count of complete, correct frames; wraps at 0xFFFF.

Behaviour:
- Reset (async assert, sync deassert on clock):
  - pix_valid, pix_sof, pix_eol, pix_eof and all err_* = 0.
  - pix_data, pix_x, pix_y = 0.
  - frame_width = MAX_WIDTH, frame_height = MAX_HEIGHT, frame_interlace = 0, frame_count = 0.
  - State = IDLE.
  - Reset mid-packet discards the packet with no error pulse.
- Handshake:
  - A beat transfers when din_valid && din_ready.
  - In IDLE, CTRL and DISCARD: din_ready = 1.
  - In VIDEO: din_ready = ~pix_valid | pix_ready, giving a single output register with no bubble under continuous ready.
  - Latency from an accepted pixel beat to pix_valid is 1 cycle.
  - pix_* outputs hold stable while pix_valid && ~pix_ready.
- IDLE:
  - Beats without SOP are dropped.
  - SOP beat with din_data[3:0] == 0xF -> CTRL, beat counter = 0.
  - SOP beat with din_data[3:0] == 0x0 -> VIDEO, x = y = 0.
  - SOP beat with any other type -> DISCARD.
  - An SOP beat that also carries EOP returns to IDLE; for type 0xF this pulses err_ctrl.
- CTRL:
  - Nine nibble beats, taken from din_data[3:0], MSB-first: width[15:0], then height[15:0], then interlace.
  - Width and height are assembled in 16-bit shadow registers.
  - EOP on beat 9 with width in 1..MAX_WIDTH and height in 1..MAX_HEIGHT: commit frame_width, frame_height and frame_interlace on the following edge, then go to IDLE.
  - EOP before beat 9, no EOP by beat 9, or out-of-range dimensions: err_ctrl pulse, previous values kept.
  - After a missing EOP, go to DISCARD; otherwise go to IDLE.
- VIDEO:
  - Every accepted beat is a pixel.
  - pix_x increments; when x == frame_width-1, pix_eol = 1, x wraps to 0 and y increments.
  - pix_sof marks x == 0, y == 0.
  - pix_eof marks x == frame_width-1, y == frame_height-1.
  - After the eof pixel, further pixels are not output; err_long pulses once, then the state goes to DISCARD until EOP.
  - EOP exactly on the eof pixel -> IDLE and frame_count + 1.
  - EOP earlier -> err_short pulse, IDLE, frame_count unchanged.
  - Dimensions are sampled at the video header and are frozen for the whole packet.
- DISCARD: accept and drop beats until EOP, then go to IDLE.
- SOP arriving outside IDLE:
  - Aborts the current packet.
  - If the state was VIDEO, err_short pulses; if it was CTRL, err_ctrl pulses.
  - The SOP beat is then parsed as a new header in the same cycle.
- Simultaneous events: err_* pulses are independent single-cycle flags and may coincide with pix_valid.

Decomposition:
- Package ast_video_pkg holds:
  - PKT_VIDEO = 4'h0 and PKT_CTRL = 4'hF.
  - CTRL_NIBBLES = 9.
  - Enum parser_state_t with values IDLE, CTRL, VIDEO, DISCARD.
  - Coordinate width = 12.
- One sub-module, ast_pipe_reg: a one-entry valid/ready output register carrying data plus the x, y, sof, eol and eof tags.

Test Plan:
- Control packet 0F,0,2,8,0,0,1,E,0,0 (EOP on the last beat) -> frame_width = 640, frame_height = 480, no error pulse.
- Control packet for 4x2, then video 00,p0..p7 with EOP on p7:
  - pix_eol on p3 and p7; pix_sof on p0; pix_eof on p7.
  - x/y run (0,0)..(3,1); frame_count = 1.
- Same 4x2 video with EOP on p5 -> one err_short pulse; frame_count unchanged; the next SOP parses normally.
- 4x2 video with 10 pixels -> 8 pixels output; err_long pulses once; DISCARD until EOP.
- pix_ready toggled 1,0,0,1 during the 4x2 video -> no pixel lost or duplicated; pix_* held stable while stalled; din_ready = 0 only while stalled with output full.
- Control packet with width nibbles 0,3,0,0 (768) -> err_ctrl pulse; dimensions stay 4x2. Separately, reset_n pulsed low mid-video -> all outputs return to reset values.

Source files
------------

// File: rtl/ast_video_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ast_video_pkg : shared packet types, parser states and widths
// Rev 1.0
// ---------------------------------------------------------------------------
package ast_video_pkg;

  localparam logic [3:0] PKT_VIDEO    = 4'h0;
  localparam logic [3:0] PKT_CTRL     = 4'hF;
  localparam int         CTRL_NIBBLES = 9;
  localparam int         COORD_W      = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CTRL    = 2'd1,
    VIDEO   = 2'd2,
    DISCARD = 2'd3
  } parser_state_t;

endpackage
`default_nettype wire

// File: rtl/ast_pipe_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ast_pipe_reg : one-entry valid/ready register for a pixel and its tags
// Rev 1.0
// ---------------------------------------------------------------------------
module ast_pipe_reg
  import ast_video_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [COORD_W-1:0]    in_x,
  input  logic [COORD_W-1:0]    in_y,
  input  logic                  in_sof,
  input  logic                  in_eol,
  input  logic                  in_eof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [COORD_W-1:0]    out_x,
  output logic [COORD_W-1:0]    out_y,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [COORD_W-1:0]    x_q,     x_d;
  logic [COORD_W-1:0]    y_q,     y_d;
  logic [2:0]            tag_q,   tag_d;

  // Refill in the same cycle the held entry leaves, so no bubble under steady ready.
  assign in_ready = ~valid_q | out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    x_d     = x_q;
    y_d     = y_q;
    tag_d   = tag_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      x_d     = in_x;
      y_d     = in_y;
      tag_d   = {in_sof, in_eol, in_eof};
    end else if (out_ready) begin
      valid_d = 1'b0;
      tag_d   = 3'b000;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      tag_q   <= 3'b000;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_sof   = tag_q[2];
  assign out_eol   = tag_q[1];
  assign out_eof   = tag_q[0];

endmodule
`default_nettype wire

// File: rtl/ast_video_frame_parser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ast_video_frame_parser : Avalon-ST video sink, control/video packet parser
// Rev 1.0
// ---------------------------------------------------------------------------
module ast_video_frame_parser
  import ast_video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 640,
  parameter int MAX_HEIGHT = 480
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [COORD_W-1:0]    pix_x,
  output logic [COORD_W-1:0]    pix_y,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic [COORD_W-1:0]    frame_width,
  output logic [COORD_W-1:0]    frame_height,
  output logic [3:0]            frame_interlace,
  output logic                  err_ctrl,
  output logic                  err_short,
  output logic                  err_long,
  output logic [15:0]           frame_count
);

  parser_state_t      state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        shw_q, shw_d;
  logic [15:0]        shh_q, shh_d;
  logic [COORD_W-1:0] vw_q, vw_d;
  logic [COORD_W-1:0] vh_q, vh_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               done_q, done_d;
  logic [COORD_W-1:0] fw_q, fw_d;
  logic [COORD_W-1:0] fh_q, fh_d;
  logic [3:0]         fi_q, fi_d;
  logic [15:0]        fc_q, fc_d;
  logic               err_ctrl_q, err_ctrl_d;
  logic               err_short_q, err_short_d;
  logic               err_long_q, err_long_d;

  logic               pipe_ready;
  logic               pix_load;
  logic               beat_acc;
  logic [3:0]         nib;
  logic               dims_ok;
  logic               at_eol;
  logic               at_eof;

  assign din_ready = (state_q == VIDEO) ? pipe_ready : 1'b1;
  assign beat_acc  = din_valid & din_ready;
  assign nib       = din_data[3:0];
  assign dims_ok   = (shw_q != 16'd0) && (shw_q <= 16'(MAX_WIDTH)) &&
                     (shh_q != 16'd0) && (shh_q <= 16'(MAX_HEIGHT));
  assign at_eol    = (x_q == vw_q - 12'd1);
  assign at_eof    = at_eol && (y_q == vh_q - 12'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shw_d       = shw_q;
    shh_d       = shh_q;
    vw_d        = vw_q;
    vh_d        = vh_q;
    x_d         = x_q;
    y_d         = y_q;
    done_d      = done_q;
    fw_d        = fw_q;
    fh_d        = fh_q;
    fi_d        = fi_q;
    fc_d        = fc_q;
    err_ctrl_d  = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    pix_load    = 1'b0;

    if (beat_acc) begin
      if (din_startofpacket) begin
        // An SOP always starts a new header, aborting whatever was in progress.
        if (state_q == CTRL)  err_ctrl_d  = 1'b1;
        if (state_q == VIDEO) err_short_d = 1'b1;
        case (nib)
          PKT_CTRL: begin
            cnt_d = 4'd0;
            shw_d = 16'd0;
            shh_d = 16'd0;
            if (din_endofpacket) begin
              err_ctrl_d = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d    = CTRL;
            end
          end
          PKT_VIDEO: begin
            x_d     = '0;
            y_d     = '0;
            done_d  = 1'b0;
            vw_d    = fw_q;
            vh_d    = fh_q;
            state_d = din_endofpacket ? IDLE : VIDEO;
          end
          default: state_d = din_endofpacket ? IDLE : DISCARD;
        endcase
      end else begin
        case (state_q)
          CTRL: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q < 4'd4)      shw_d = {shw_q[11:0], nib};
            else if (cnt_q < 4'd8) shh_d = {shh_q[11:0], nib};
            if (cnt_q == 4'(CTRL_NIBBLES - 1)) begin
              if (din_endofpacket && dims_ok) begin
                fw_d = shw_q[COORD_W-1:0];
                fh_d = shh_q[COORD_W-1:0];
                fi_d = nib;
              end else begin
                err_ctrl_d = 1'b1;
              end
              state_d = din_endofpacket ? IDLE : DISCARD;
            end else if (din_endofpacket) begin
              err_ctrl_d = 1'b1;
              state_d    = IDLE;
            end
          end
          VIDEO: begin
            if (done_q) begin
              err_long_d = 1'b1;
              state_d    = din_endofpacket ? IDLE : DISCARD;
            end else begin
              pix_load = 1'b1;
              if (at_eol) begin
                x_d = '0;
                y_d = y_q + 12'd1;
              end else begin
                x_d = x_q + 12'd1;
              end
              if (at_eof) begin
                if (din_endofpacket) begin
                  fc_d    = fc_q + 16'd1;
                  state_d = IDLE;
                end else begin
                  done_d  = 1'b1;
                end
              end else if (din_endofpacket) begin
                err_short_d = 1'b1;
                state_d     = IDLE;
              end
            end
          end
          DISCARD: if (din_endofpacket) state_d = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shw_q       <= 16'd0;
      shh_q       <= 16'd0;
      vw_q        <= 12'(MAX_WIDTH);
      vh_q        <= 12'(MAX_HEIGHT);
      x_q         <= '0;
      y_q         <= '0;
      done_q      <= 1'b0;
      fw_q        <= 12'(MAX_WIDTH);
      fh_q        <= 12'(MAX_HEIGHT);
      fi_q        <= 4'd0;
      fc_q        <= 16'd0;
      err_ctrl_q  <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shw_q       <= shw_d;
      shh_q       <= shh_d;
      vw_q        <= vw_d;
      vh_q        <= vh_d;
      x_q         <= x_d;
      y_q         <= y_d;
      done_q      <= done_d;
      fw_q        <= fw_d;
      fh_q        <= fh_d;
      fi_q        <= fi_d;
      fc_q        <= fc_d;
      err_ctrl_q  <= err_ctrl_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  ast_pipe_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (pix_load),
    .in_ready  (pipe_ready),
    .in_data   (din_data),
    .in_x      (x_q),
    .in_y      (y_q),
    .in_sof    ((x_q == '0) && (y_q == '0)),
    .in_eol    (at_eol),
    .in_eof    (at_eof),
    .out_valid (pix_valid),
    .out_ready (pix_ready),
    .out_data  (pix_data),
    .out_x     (pix_x),
    .out_y     (pix_y),
    .out_sof   (pix_sof),
    .out_eol   (pix_eol),
    .out_eof   (pix_eof)
  );

  assign frame_width     = fw_q;
  assign frame_height    = fh_q;
  assign frame_interlace = fi_q;
  assign frame_count     = fc_q;
  assign err_ctrl        = err_ctrl_q;
  assign err_short       = err_short_q;
  assign err_long        = err_long_q;

endmodule
`default_nettype wire

// File: tb/tb_ast_video_frame_parser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ast_video_frame_parser : directed + random bench with a packet-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ast_video_frame_parser;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  din_data = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_startofpacket = 1'b0;
  logic        din_endofpacket = 1'b0;
  logic        din_ready;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic [11:0] pix_x, pix_y;
  logic        pix_sof, pix_eol, pix_eof;
  logic [11:0] frame_width, frame_height;
  logic [3:0]  frame_interlace;
  logic        err_ctrl, err_short, err_long;
  logic [15:0] frame_count;

  ast_video_frame_parser dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .din_data          (din_data),
    .din_valid         (din_valid),
    .din_startofpacket (din_startofpacket),
    .din_endofpacket   (din_endofpacket),
    .din_ready         (din_ready),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_x             (pix_x),
    .pix_y             (pix_y),
    .pix_sof           (pix_sof),
    .pix_eol           (pix_eol),
    .pix_eof           (pix_eof),
    .frame_width       (frame_width),
    .frame_height      (frame_height),
    .frame_interlace   (frame_interlace),
    .err_ctrl          (err_ctrl),
    .err_short         (err_short),
    .err_long          (err_long),
    .frame_count       (frame_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  localparam int M_IDLE = 0, M_CTRL = 1, M_VID = 2, M_DISC = 3;

  typedef struct {
    logic [7:0] d;
    int x, y;
    bit sof, eol, eof;
  } pix_t;

  pix_t       pq[$];
  logic [3:0] nq[$];
  int         m_mode, m_n, m_w, m_h;
  int         m_fw, m_fh, m_fi;
  logic [15:0] m_fc;
  bit         e_ctrl, e_short, e_long;

  task automatic model_reset();
    pq.delete(); nq.delete();
    m_mode = M_IDLE; m_n = 0; m_w = 640; m_h = 480;
    m_fw = 640; m_fh = 480; m_fi = 0; m_fc = 16'd0;
    e_ctrl = 0; e_short = 0; e_long = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input bit sop, input bit eop);
    int w, h, total;
    pix_t p;
    if (sop) begin
      if (m_mode == M_CTRL) e_ctrl = 1;
      if (m_mode == M_VID)  e_short = 1;
      if (d[3:0] == 4'hF) begin
        nq.delete();
        if (eop) e_ctrl = 1;
        m_mode = eop ? M_IDLE : M_CTRL;
      end else if (d[3:0] == 4'h0) begin
        m_n = 0; m_w = m_fw; m_h = m_fh;
        m_mode = eop ? M_IDLE : M_VID;
      end else begin
        m_mode = eop ? M_IDLE : M_DISC;
      end
    end else if (m_mode == M_CTRL) begin
      nq.push_back(d[3:0]);
      if (nq.size() == 9) begin
        w = int'(nq[0]) * 4096 + int'(nq[1]) * 256 + int'(nq[2]) * 16 + int'(nq[3]);
        h = int'(nq[4]) * 4096 + int'(nq[5]) * 256 + int'(nq[6]) * 16 + int'(nq[7]);
        if (eop && w >= 1 && w <= 640 && h >= 1 && h <= 480) begin
          m_fw = w; m_fh = h; m_fi = int'(nq[8]);
        end else e_ctrl = 1;
        m_mode = eop ? M_IDLE : M_DISC;
      end else if (eop) begin
        e_ctrl = 1; m_mode = M_IDLE;
      end
    end else if (m_mode == M_VID) begin
      total = m_w * m_h;
      if (m_n == total) begin
        e_long = 1;
        m_mode = eop ? M_IDLE : M_DISC;
      end else begin
        p.d = d; p.x = m_n % m_w; p.y = m_n / m_w;
        p.sof = (m_n == 0); p.eol = (p.x == m_w - 1); p.eof = (m_n == total - 1);
        pq.push_back(p);
        m_n++;
        if (m_n == total) begin
          if (eop) begin m_fc = m_fc + 16'd1; m_mode = M_IDLE; end
        end else if (eop) begin
          e_short = 1; m_mode = M_IDLE;
        end
      end
    end else if (m_mode == M_DISC) begin
      if (eop) m_mode = M_IDLE;
    end
  endtask

  // ---------------- observed tallies (compared against literals) ----------------
  int n_pix = 0, n_sof = 0, n_eol = 0, n_eof = 0;
  int n_ec = 0, n_es = 0, n_el = 0;

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_data",  pix_data, 0);
      chk("rst_pix_xy",    {pix_x, pix_y}, 0);
      chk("rst_tags",      {pix_sof, pix_eol, pix_eof}, 0);
      chk("rst_errs",      {err_ctrl, err_short, err_long}, 0);
      chk("rst_width",     frame_width, 640);
      chk("rst_height",    frame_height, 480);
      chk("rst_interlace", frame_interlace, 0);
      chk("rst_count",     frame_count, 0);
      model_reset();
    end else begin
      chk("pix_valid", pix_valid, (pq.size() != 0));
      if (pix_valid && pq.size() != 0) begin
        chk("pix_data", pix_data, pq[0].d);
        chk("pix_x", pix_x, 32'(pq[0].x));
        chk("pix_y", pix_y, 32'(pq[0].y));
        chk("pix_tags", {pix_sof, pix_eol, pix_eof}, {pq[0].sof, pq[0].eol, pq[0].eof});
        if (pix_ready) begin
          void'(pq.pop_front());
          n_pix++;
          if (pix_sof) n_sof++;
          if (pix_eol) n_eol++;
          if (pix_eof) n_eof++;
        end
      end
      chk("err_ctrl",  err_ctrl,  e_ctrl);
      chk("err_short", err_short, e_short);
      chk("err_long",  err_long,  e_long);
      if (err_ctrl)  n_ec++;
      if (err_short) n_es++;
      if (err_long)  n_el++;
      chk("frame_width",     frame_width, 32'(m_fw));
      chk("frame_height",    frame_height, 32'(m_fh));
      chk("frame_interlace", frame_interlace, 32'(m_fi));
      chk("frame_count",     frame_count, m_fc);
      chk("din_ready", din_ready, (m_mode == M_VID) ? (pq.size() == 0 || pix_ready) : 1'b1);
      e_ctrl = 0; e_short = 0; e_long = 0;
      if (din_valid && din_ready) model_step(din_data, din_startofpacket, din_endofpacket);
    end
  end

  // ---------------- pix_ready driver ----------------
  int rdy_mode = 0;
  int pat_i = 0;
  bit pat[4];
  initial begin
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
  end

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ($urandom_range(0, 3) != 0);
      default: begin pix_ready = pat[pat_i]; pat_i = (pat_i + 1) % 4; end
    endcase
  end

  // ---------------- stimulus ----------------
  int gap_max = 0;
  logic [7:0] pd[$];

  task automatic send_beat(input logic [7:0] d, input bit sop, input bit eop);
    int gap;
    gap = $urandom_range(0, gap_max);
    repeat (gap) begin
      din_valid = 1'b0; din_data = 8'($urandom);
      din_startofpacket = 1'($urandom); din_endofpacket = 1'($urandom);
      @(posedge clock); #1;
    end
    din_valid = 1'b1; din_data = d; din_startofpacket = sop; din_endofpacket = eop;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clock);
      if (din_ready) begin
        @(posedge clock); #1;
        din_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    n_checks++; n_err++;
    $display("FAIL beat_accept_timeout: got no din_ready required 1 within 2000 cycles");
    din_valid = 1'b0;
  endtask

  task automatic send_pkt(input bit eop_last);
    for (int i = 0; i < pd.size(); i++)
      send_beat(pd[i], (i == 0), eop_last && (i == pd.size() - 1));
    pd.delete();
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic add_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    pd.push_back({4'($urandom), 4'hF});
    for (int i = 3; i >= 0; i--) pd.push_back({4'($urandom), w[i*4 +: 4]});
    for (int i = 3; i >= 0; i--) pd.push_back({4'($urandom), h[i*4 +: 4]});
    pd.push_back({4'($urandom), il});
  endtask

  task automatic add_video(input int npix);
    pd.push_back({4'($urandom), 4'h0});
    for (int i = 0; i < npix; i++) pd.push_back(8'($urandom));
  endtask

  task automatic do_reset(input int cyc);
    din_valid = 1'b0;
    #1 reset_n = 1'b0;
    repeat (cyc) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  int b_pix, b_sof, b_eol, b_eof, b_ec, b_es, b_el;
  task automatic snap();
    b_pix = n_pix; b_sof = n_sof; b_eol = n_eol; b_eof = n_eof;
    b_ec = n_ec; b_es = n_es; b_el = n_el;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;

    // 640x480 control packet from the literal beat list
    snap();
    pd = '{8'h0F, 8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h01, 8'h0E, 8'h00, 8'h00};
    send_pkt(1);
    idle(5);
    chk("t1_width", frame_width, 640);
    chk("t1_height", frame_height, 480);
    chk("t1_no_err", n_ec - b_ec, 0);

    // 4x2 frame
    add_ctrl(16'd4, 16'd2, 4'h3);
    send_pkt(1);
    idle(5);
    chk("t2_width", frame_width, 4);
    chk("t2_height", frame_height, 2);
    chk("t2_interlace", frame_interlace, 3);

    snap();
    add_video(8); send_pkt(1); idle(6);
    chk("t3_count", frame_count, 1);
    chk("t3_pix", n_pix - b_pix, 8);
    chk("t3_sof", n_sof - b_sof, 1);
    chk("t3_eol", n_eol - b_eol, 2);
    chk("t3_eof", n_eof - b_eof, 1);

    snap();
    add_video(6); send_pkt(1); idle(6);
    chk("t4_short", n_es - b_es, 1);
    chk("t4_count", frame_count, 1);
    add_video(8); send_pkt(1); idle(6);
    chk("t4_next_count", frame_count, 2);

    snap();
    add_video(10); send_pkt(1); idle(6);
    chk("t5_pix", n_pix - b_pix, 8);
    chk("t5_long", n_el - b_el, 1);
    chk("t5_count", frame_count, 2);

    snap();
    pat_i = 0; rdy_mode = 2;
    add_video(8); send_pkt(1); idle(8);
    rdy_mode = 0; idle(2);
    chk("t6_pix", n_pix - b_pix, 8);
    chk("t6_count", frame_count, 3);

    snap();
    add_ctrl(16'd768, 16'd2, 4'h0); send_pkt(1); idle(5);
    chk("t7_ctrl_err", n_ec - b_ec, 1);
    chk("t7_width", frame_width, 4);

    add_video(3); send_pkt(0);
    do_reset(2);
    @(posedge clock); #1;
    chk("t8_width", frame_width, 640);
    chk("t8_count", frame_count, 0);
    chk("t8_pix_valid", pix_valid, 0);

    // randomized traffic
    gap_max = 2; rdy_mode = 1;
    for (int k = 0; k < 120; k++) begin
      int kind, r, len, base, n;
      logic [15:0] w, h;
      bit eopl;
      kind = $urandom_range(0, 9);
      eopl = ($urandom_range(0, 7) != 0);
      if (kind < 3) begin
        w = 16'($urandom_range(1, 6)); h = 16'($urandom_range(1, 4));
        len = 9; r = $urandom_range(0, 9);
        if (r == 0) w = 16'd0;
        else if (r == 1) h = 16'd500;
        else if (r == 2) len = 8;
        else if (r == 3) len = 10;
        add_ctrl(w, h, 4'($urandom));
        if (len == 8) void'(pd.pop_back());
        if (len == 10) pd.push_back(8'($urandom));
        send_pkt(eopl);
      end else if (kind < 8) begin
        base = m_fw * m_fh;
        if (base > 40) base = 40;
        n = base + $urandom_range(0, 4) - 2;
        if (n < 1) n = 1;
        add_video(n);
        send_pkt(eopl);
      end else if (kind == 8) begin
        pd.push_back({4'($urandom), 4'($urandom_range(1, 14))});
        for (int i = 0; i < $urandom_range(0, 3); i++) pd.push_back(8'($urandom));
        send_pkt(eopl);
      end else begin
        send_beat(8'($urandom), 1'b0, 1'($urandom));
      end
    end
    rdy_mode = 0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
